// File: rtl/cte_out_collector.sv
// Output collector for the colour-transform engine: captures RGB pixels or
// byte-serial YUV samples packed into 32-bit words, buffered in a FWFT FIFO.
module cte_out_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_mode,
  input  logic          out_valid,
  input  logic [23:0]   rgb_out,
  input  logic [7:0]    yuv_out,
  input  logic          clr,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [31:0]   o_data,
  output logic          o_tag,
  output logic [AW:0]   o_count,
  output logic          stall_req,
  output logic          overflow,
  output logic          frag_err
);

  localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;

  // Entry layout: {tag, data[31:0]}.
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;

  logic          mode_q;
  logic [1:0]    byte_idx;
  logic [31:0]   asm_q;

  logic          mode_chg, yuv_cap, rgb_cap, yuv_last;
  logic [1:0]    idx_eff;
  logic [31:0]   asm_eff, asm_wr;
  logic          push_req, full, pop, accept, drop;
  logic [32:0]   push_word, head;

  always_comb begin
    // A mode switch mid-word restarts the assembler before this cycle's byte.
    mode_chg = (op_mode != mode_q) && (byte_idx != 2'd0);
    idx_eff  = mode_chg ? 2'd0 : byte_idx;
    asm_eff  = mode_chg ? '0 : asm_q;
    yuv_cap  = out_valid & op_mode;
    rgb_cap  = out_valid & ~op_mode;
    yuv_last = yuv_cap & ~clr & (idx_eff == 2'd3);

    asm_wr = asm_eff;
    case (idx_eff)
      2'd0:    asm_wr[31:24] = yuv_out;
      2'd1:    asm_wr[23:16] = yuv_out;
      2'd2:    asm_wr[15:8]  = yuv_out;
      default: asm_wr[7:0]   = yuv_out;
    endcase

    push_req  = rgb_cap | yuv_last;
    // The last byte bypasses the assembler register straight into the word.
    push_word = rgb_cap ? {1'b0, 8'h00, rgb_out} : {1'b1, asm_eff[31:8], yuv_out};

    full   = (count_q == DEPTH_CNT);
    pop    = o_valid & o_ready;
    accept = push_req & (~full | pop);
    drop   = push_req & full & ~pop;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 1'b0;
      byte_idx <= 2'd0;
      asm_q    <= '0;
      overflow <= 1'b0;
      frag_err <= 1'b0;
    end else begin
      mode_q <= op_mode;

      if (clr) begin
        byte_idx <= 2'd0;
        asm_q    <= '0;
      end else if (yuv_cap) begin
        byte_idx <= idx_eff + 2'd1;
        asm_q    <= (idx_eff == 2'd3) ? '0 : asm_wr;
      end else if (mode_chg) begin
        byte_idx <= 2'd0;
        asm_q    <= '0;
      end

      if (clr)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (clr)           frag_err <= 1'b0;
      else if (mode_chg) frag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; outputs are masked by o_valid, so stale
  // entries are never observable and the array maps cleanly onto RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_word;
  end

  assign head      = mem[rd_ptr];
  assign o_valid   = (count_q != '0);
  assign o_data    = o_valid ? head[31:0] : '0;
  assign o_tag     = o_valid ? head[32] : 1'b0;
  assign o_count   = count_q;
  assign stall_req = (count_q >= DEPTH_CNT - CNT_ONE);

endmodule

// File: doc/cte_out_collector.md
Name: cte_out_collector

Overview:
Downstream stage of the colour-transform engine. It captures the engine's results whenever the engine flags them valid:
- 24-bit RGB pixels in op_mode=0.
- Byte-serial YUV samples in op_mode=1, packed four at a time (U,Y0,V,Y1) into 32-bit words.

Captured words go into a small first-word-fall-through FIFO. A consumer drains the FIFO with a valid/ready handshake. An almost-full indication lets the stimulus side throttle in_en.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
AW, 2, log2(DEPTH), FIFO pointer width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op_mode  input  1  conversion mode of the engine (0 = YUV->RGB result, 1 = RGB->YUV result)
out_valid  input  1  engine result valid this cycle
rgb_out  input  24  engine RGB result {R,G,B}
yuv_out  input  8  engine YUV result byte
clr  input  1  synchronous clear of sticky flags and the byte assembler
o_valid  output  1  FIFO head word valid
o_ready  input  1  consumer accepts head word
o_data  output  32  FIFO head word
o_tag  output  1  mode tag of head word (0 = RGB, 1 = YUV)
o_count  output  AW+1  words currently stored
stall_req  output  1  almost full: o_count >= DEPTH-1
overflow  output  1  sticky: a word was dropped because the FIFO was full
frag_err  output  1  sticky: a partial YUV word was discarded

Behaviour:
- Reset is asynchronous and active-low. All state clears: FIFO pointers, o_count=0, byte_idx=0, assembler register=0, overflow=0, frag_err=0, mode_q=0. Hence o_valid=0, o_data=0, o_tag=0, stall_req=0.
- mode_q registers op_mode each cycle.
- RGB capture (out_valid=1, op_mode=0):
  - Push {8'h00, rgb_out} with tag 0 in the same edge.
  - Capture latency: the word is visible on o_data one cycle after the out_valid cycle, when the FIFO was empty.
- YUV capture (out_valid=1, op_mode=1):
  - Byte goes into slot byte_idx of the assembler, MSB first. Slot 0 = bits 31:24 (U), slot 1 = 23:16 (Y0), slot 2 = 15:8 (V), slot 3 = 7:0 (Y1).
  - byte_idx increments and wraps 3->0.
  - On the slot-3 byte, push {asm[31:8], yuv_out} with tag 1, bypassing the register for the last byte.
- Mode change: if op_mode != mode_q and byte_idx != 0:
  - Discard the partial word, set byte_idx=0, set frag_err.
  - An out_valid in that same cycle is processed under the new mode, starting at slot 0.
- FIFO is first-word-fall-through:
  - o_valid = (o_count != 0); o_data/o_tag show the head entry; they are 0 when empty.
  - Pop occurs on o_valid & o_ready.
  - Push when not full: the entry is written.
  - Push when full with a pop in the same cycle: accepted; o_count is unchanged.
  - Push when full without a pop: word dropped, overflow set, FIFO unchanged.
  - Pop and push in the same cycle when empty: the push is stored; no pop occurs since o_valid=0.
  - Pointers wrap modulo DEPTH; o_count ranges 0..DEPTH.
- o_ready while empty is ignored.
- clr:
  - Zeroes overflow, frag_err, byte_idx and the assembler the next edge.
  - Does not touch FIFO contents.
  - clr has priority over a simultaneous assembler update; a YUV byte arriving with clr is discarded.
  - A simultaneous RGB push still occurs.
- stall_req is combinational from o_count.
- Reset asserted mid-operation empties the FIFO and loses any partial word immediately; no flag survives.

Test Plan:
- RGB stream: out_valid pulses with rgb_out=24'h12_34_56, then 24'hFF_00_80, o_ready=1 -> o_data=32'h00123456 then 32'h00FF0080 with o_tag=0, each one cycle after capture; o_count returns to 0.
- YUV packing: op_mode=1, bytes 8'h80,8'h10,8'h90,8'h20 -> a single word 32'h80109020 with o_tag=1 after the 4th byte; none earlier.
- Fill/overflow: o_ready=0, DEPTH=4, five RGB results -> o_count=4, stall_req=1 from count 3, overflow=1; the 5th word is absent from the drained sequence. Next, with the FIFO full, a simultaneous push and pop is accepted with no new overflow.
- Fragment: two YUV bytes, then op_mode->0 with an RGB result in the same cycle -> frag_err=1, the RGB word is stored, and the next YUV burst starts at slot 0.
- clr and reset: clr -> flags 0 and FIFO intact. Assert reset low mid-burst with 3 words stored -> o_valid=0, o_count=0 immediately; after release, a new YUV burst packs correctly.
